pipe_vect_skid: RTL and testbench

PIPE_VECT_SKID -- requirements
Module: pipe_vect_skid

---
 rtl/pipe_vect_skid.sv | 115 +++++++++++
 tb/tb_pipe_vect_skid.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_vect_skid.sv
// Two-entry skid buffer for a scalar plus two lane-masked vectors; one cycle from accept to out_valid.
// in_ready is decoded from registered state only, so downstream stalls never reach upstream combinationally.
module pipe_vect_skid #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         in,
  input  logic [vectorSize-1:0][registerSize-1:0]  vect1,
  input  logic [vectorSize-1:0][registerSize-1:0]  vect2,
  input  logic [vectorSize-1:0]                    lane_mask,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WIDTH-1:0]                         out,
  output logic [vectorSize-1:0][registerSize-1:0]  vect1_out,
  output logic [vectorSize-1:0][registerSize-1:0]  vect2_out,
  output logic [1:0]                               occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0]                        scalar;
    logic [vectorSize-1:0][registerSize-1:0] v1;
    logic [vectorSize-1:0][registerSize-1:0] v2;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   in_fire;
  logic   out_fire;

  // Masked-off lanes are stored as zero; the scalar always passes untouched.
  always_comb begin
    in_beat.scalar = in;
    for (int i = 0; i < vectorSize; i++) begin
      in_beat.v1[i] = lane_mask[i] ? vect1[i] : '0;
      in_beat.v2[i] = lane_mask[i] ? vect2[i] : '0;
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_beat;
          end else if (in_fire) begin
            skid_d  = in_beat;
            state_d = FULL;
          end else if (out_fire) begin
            // Output data is left in place; only reset and flush clear it.
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out       = main_q.scalar;
  assign vect1_out = main_q.v1;
  assign vect2_out = main_q.v2;
  assign occupancy = 2'(state_q);

endmodule

// File: tb/tb_pipe_vect_skid.sv
// Bench for pipe_vect_skid: directed scenarios then random traffic, all scored against a queue model.
module tb_pipe_vect_skid;
  localparam int W = 8;
  localparam int R = 8;
  localparam int V = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, flush, in_valid, out_ready;
  logic                 in_ready, out_valid;
  logic [W-1:0]         in, out;
  logic [V-1:0][R-1:0]  vect1, vect2, vect1_out, vect2_out;
  logic [V-1:0]         lane_mask;
  logic [1:0]           occupancy;

  pipe_vect_skid #(.WIDTH(W), .registerSize(R), .vectorSize(V)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .vect1(vect1), .vect2(vect2), .lane_mask(lane_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .vect1_out(vect1_out), .vect2_out(vect2_out), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [W-1:0]   s;
    logic [V*R-1:0] a;
    logic [V*R-1:0] b;
  } beat_t;

  beat_t q[$];
  beat_t shown;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic logic [V*R-1:0] maskv(input logic [V*R-1:0] v, input logic [V-1:0] m);
    logic [V*R-1:0] r;
    r = v;
    for (int i = 0; i < V; i++)
      if (!m[i]) r[i*R +: R] = '0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One clock: model predicts handshakes from its pre-edge contents, then all outputs are compared.
  task automatic step();
    bit    exp_rdy, exp_vld, ifire, ofire;
    beat_t nb;
    exp_rdy = (q.size() < 2);
    exp_vld = (q.size() > 0);
    ifire   = in_valid && exp_rdy;
    ofire   = exp_vld && out_ready;
    nb.s    = in;
    nb.a    = maskv(vect1, lane_mask);
    nb.b    = maskv(vect2, lane_mask);
    @(posedge clk);
    #1;
    if (reset || flush) begin
      q.delete();
      shown = '0;
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(nb);
      if (q.size() > 0) shown = q[0];
    end
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
    chk("out",       64'(out),       64'(shown.s));
    chk("vect1_out", 64'(vect1_out), 64'(shown.a));
    chk("vect2_out", 64'(vect2_out), 64'(shown.b));
  endtask

  task automatic offer(input logic [W-1:0] s);
    in_valid = 1'b1;
    in       = s;
    vect1    = {8'd4, 8'd3, 8'd2, 8'd1};
    vect2    = {8'd40, 8'd30, 8'd20, 8'd10};
    lane_mask = 4'b1111;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in = 8'h99; vect1 = '1; vect2 = '1; lane_mask = '1;

    // Reset with a beat offered: nothing may be captured.
    step();
    chk("reset_occ", 64'(occupancy), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();

    // Back-to-back stream, one cycle of latency each.
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      offer(8'(k));
      step();
      chk("stream_out", 64'(out), 64'(k));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Lane mask 0101 keeps lanes 0 and 2.
    offer(8'hA5);
    vect1 = {8'd44, 8'd33, 8'd22, 8'd11};
    lane_mask = 4'b0101;
    step();
    chk("mask_out", 64'(out), 64'hA5);
    chk("mask_vect1", 64'(vect1_out), 64'({8'd0, 8'd33, 8'd0, 8'd11}));
    in_valid = 1'b0;
    step();

    // Stall: fill both entries, third beat refused, then drain in order.
    out_ready = 1'b0;
    offer(8'h10); step();
    offer(8'h20); step();
    chk("full_occ", 64'(occupancy), 64'd2);
    offer(8'h30); step(); step();
    chk("full_hold", 64'(out), 64'h10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_no_comb", 64'(in_ready), 64'd0);
    step();
    chk("drain_second", 64'(out), 64'h20);
    step();
    chk("drain_empty", 64'(occupancy), 64'd0);

    // Flush while full with a beat offered.
    out_ready = 1'b0;
    offer(8'h41); step();
    offer(8'h42); step();
    offer(8'h55); flush = 1'b1;
    step();
    chk("flush_out", 64'(out), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // Reset and flush together while full, then a fresh beat.
    out_ready = 1'b0;
    offer(8'h61); step();
    offer(8'h62); step();
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    offer(8'h7F);
    step();
    chk("post_reset_beat", 64'(out), 64'h7F);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 255) == 0);
      in        = 8'($urandom);
      vect1     = 32'($urandom);
      vect2     = 32'($urandom);
      lane_mask = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
